rf_wb_ctrl: RTL and testbench
=============================

# rf_wb_ctrl

Writeback controller for the integer register file: shares the file's single write port between NREQ writeback requesters with round-robin arbitration, and keeps a busy-bit scoreboard of destination registers that have issued but not yet been written. It sits between the execute/LSU writeback sources and the register file write port, and feeds a RAW/WAW hazard signal back to decode.

## Interface
- ADDR_WIDTH, 5, register address width; 2**ADDR_WIDTH registers, x0 hardwired zero
- DATA_WIDTH, 64, register data width
- NREQ, 3, number of writeback requesters, 2..8
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; synchronous and active-high
- wb_valid  in  NREQ  requester i has a write pending
- wb_ready  out  NREQ  requester i's write accepted this cycle
- wb_addr  in  NREQ*ADDR_WIDTH  packed destination addresses, requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- wb_data  in  NREQ*DATA_WIDTH  packed write data, same packing
- rf_wen  out  1  register file write enable
- rf_waddr  out  ADDR_WIDTH  register file write address
- rf_wdata  out  DATA_WIDTH  register file write data
- iss_valid  in  1  decode issuing an instruction that writes iss_addr
- iss_addr  in  ADDR_WIDTH  destination of issuing instruction
- iss_ready  out  1  issue accepted
- rs1_addr, rs2_addr  in  ADDR_WIDTH each  source registers of the instruction in decode
- hazard  out  1  a source or the destination is busy

## Operation
- Handshake: transfer on wb_valid[i] & wb_ready[i]. Requester holds wb_valid, wb_addr, wb_data stable until accepted. wb_ready is combinational from wb_valid and the RR pointer; at most one bit set per cycle.
- Arbitration: round-robin pointer ptr (0..NREQ-1). Search order ptr, ptr+1, …, wrapping mod NREQ; the first valid requester is granted. On a grant to i, ptr <= (i+1) mod NREQ. With no grant, ptr holds.
- Write stage: an accepted write is registered; the next cycle rf_wen=1 (0 if the address is 0), rf_waddr and rf_wdata hold the accepted values. With no accept, rf_wen=0 and addr/data hold their last values.
- Scoreboard: busy[2**ADDR_WIDTH-1:0]; busy[0] is always 0.
  - Issue: iss_ready = !busy[iss_addr] | (iss_addr==0). On iss_valid & iss_ready with iss_addr≠0, busy[iss_addr] <= 1.
  - Clear: on the edge that commits rf_wen with rf_waddr=a, busy[a] <= 0. This is the same edge at which the file captures the data.
  - Same-cycle issue to a and clear of a: issue sees the pre-clear busy, so it is refused that cycle. Set and clear never collide.
  - A writeback to a non-busy register is still written; busy is unchanged.
- hazard = (busy[rs1_addr] & rs1_addr≠0) | (busy[rs2_addr] & rs2_addr≠0) | (iss_valid & !iss_ready).

## Timing
- Reset values: rf_wen=0, rf_waddr=0, rf_wdata=0, ptr=0, busy all 0. wb_ready=0 and iss_ready=0 while rst=1; issue and writeback are ignored.
- Writeback latency: accept in cycle N, rf_wen in cycle N+1, file updated and busy cleared at the end of N+1. A read in N+2 returns the new value and hazard is already 0.
- Throughput: one write per cycle sustained.
- Reset mid-operation: a write already on rf_wen during the reset cycle still lands in the file (the file has no reset). Everything not yet accepted is dropped; the pending writes are the requesters' responsibility.

## Configuration
- RF_SCOREBOARD_EN defined: the busy array, iss_ready gating and hazard are built as described.
- RF_SCOREBOARD_EN undefined: no busy state. iss_ready=1 (0 during reset), hazard=0, and the arbiter and write stage are unchanged.

## Structure
- Package rf_wb_pkg holds the default ADDR_WIDTH, DATA_WIDTH and NREQ constants, and a function to extract packed lane i.
- Sub-module rf_rr_arbiter (parameter N) contains the request vector, one-hot grant, pointer register and synchronous reset. rf_wb_ctrl instantiates it once.

## Test plan
- Reset, then wb_valid=3'b111 with addrs 1/2/3 for 3 cycles -> grants in order 0,1,2; rf_wen writes x1,x2,x3 on cycles 2,3,4.
- Requester 1 only, addr 5, data 64'hDEAD_BEEF accepted in cycle N -> rf_wen=1, rf_waddr=5, rf_wdata=64'hDEAD_BEEF in N+1; rf_wen=0 in N+2.
- Issue x7, then rs1=7 -> hazard=1. Writeback to x7 accepted in cycle N -> hazard=1 in N+1, 0 in N+2; a second issue to x7 is refused in N+1 and accepted in N+2.
- Writeback to x0 with data 64'h1 -> wb_ready=1 and rf_wen stays 0. Issue to x0 -> iss_ready=1 and busy unchanged; rs1=0 never raises hazard.
- rst asserted the cycle after an accept -> that write still appears on rf_wen. The next cycle all outputs are at reset values, busy is all 0 and ptr=0.
- With RF_SCOREBOARD_EN undefined: issue x4 then rs1=4 -> hazard=0 and iss_ready=1 throughout.

Source files
------------

// File: rtl/rf_wb_pkg.sv
// Shared constants and lane helper for the register-file writeback controller.
// Optional feature macro: RF_SCOREBOARD_EN (busy-bit scoreboard and hazard logic).
package rf_wb_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 5;
  localparam int unsigned DEF_DATA_WIDTH = 64;
  localparam int unsigned DEF_NREQ       = 3;

  // Upper bounds the lane helper is sized for.
  localparam int unsigned MAX_NREQ   = 8;
  localparam int unsigned MAX_LANE_W = 64;
  localparam int unsigned MAX_BUS_W  = MAX_NREQ * MAX_LANE_W;

  // Extract lane idx of width lane_w from a packed bus; the caller truncates to lane_w.
  function automatic logic [MAX_LANE_W-1:0] get_lane(input logic [MAX_BUS_W-1:0] bus,
                                                     input int unsigned lane_w,
                                                     input int unsigned idx);
    return MAX_LANE_W'(bus >> (lane_w * idx));
  endfunction

endpackage

// File: rtl/rf_wb_ctrl_if.sv
// Writeback requester bus: NREQ packed valid/ready/address/data lanes.
interface rf_wb_ctrl_if
  import rf_wb_pkg::*;
#(
  parameter int unsigned NREQ       = DEF_NREQ,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);

  logic [NREQ-1:0]            wb_valid;
  logic [NREQ-1:0]            wb_ready;
  logic [NREQ*ADDR_WIDTH-1:0] wb_addr;
  logic [NREQ*DATA_WIDTH-1:0] wb_data;

  modport master (output wb_valid, output wb_addr, output wb_data, input wb_ready);
  modport slave  (input wb_valid, input wb_addr, input wb_data, output wb_ready);

endinterface

// File: rtl/rf_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from ptr, ptr moves past the winner.
module rf_rr_arbiter #(
  parameter int unsigned N = 3,
  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt_c,
  output logic [PTR_W-1:0] gnt_idx_c
);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] cand;
  logic             found;

  // First requester at or after ptr (wrapping) wins; nothing is granted in reset.
  always_comb begin
    gnt_c     = '0;
    gnt_idx_c = '0;
    cand      = '0;
    found     = rst;
    for (int unsigned k = 0; k < N; k++) begin
      cand = PTR_W'((32'(ptr) + k) % N);
      if (!found && req[cand]) begin
        gnt_c[cand] = 1'b1;
        gnt_idx_c   = cand;
        found       = 1'b1;
      end
    end
  end

  // Pointer advances to the slot after the granted requester, holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (|gnt_c) begin
      ptr <= (gnt_idx_c == PTR_W'(N - 1)) ? '0 : gnt_idx_c + PTR_W'(1);
    end
  end

endmodule

// File: rtl/rf_wb_ctrl.sv
// Register-file writeback controller: round-robin shares the single write port
// among NREQ requesters and, with RF_SCOREBOARD_EN defined, tracks in-flight
// destinations in a busy-bit scoreboard that drives iss_ready and hazard.
module rf_wb_ctrl
  import rf_wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned NREQ       = DEF_NREQ
) (
  input  logic                  clk,
  input  logic                  rst,
  rf_wb_ctrl_if.slave           wb,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_addr,
  output logic                  iss_ready,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic                  hazard
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       gnt;
  logic [PTR_W-1:0]      gnt_idx;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  rf_rr_arbiter #(.N(NREQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (wb.wb_valid),
    .gnt_c     (gnt),
    .gnt_idx_c (gnt_idx)
  );

  assign wb.wb_ready = gnt;
  assign accept      = |gnt;

  // Winning lane's address and data.
  always_comb begin
    sel_addr = ADDR_WIDTH'(get_lane(MAX_BUS_W'(wb.wb_addr), ADDR_WIDTH, 32'(gnt_idx)));
    sel_data = DATA_WIDTH'(get_lane(MAX_BUS_W'(wb.wb_data), DATA_WIDTH, 32'(gnt_idx)));
  end

  // Write stage: register the accepted write; x0 writes keep rf_wen low.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (accept) begin
      rf_wen   <= (sel_addr != '0);
      rf_waddr <= sel_addr;
      rf_wdata <= sel_data;
    end else begin
      rf_wen   <= 1'b0;
    end
  end

`ifdef RF_SCOREBOARD_EN
  localparam int unsigned NREG = 2 ** ADDR_WIDTH;

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic            iss_fire;

  // Issue is refused while its destination is still in flight (x0 never is).
  always_comb begin
    iss_ready = !rst && (!busy[iss_addr] || (iss_addr == '0));
    iss_fire  = iss_valid && iss_ready && (iss_addr != '0);
    hazard    = (busy[rs1_addr] && (rs1_addr != '0)) ||
                (busy[rs2_addr] && (rs2_addr != '0)) ||
                (iss_valid && !iss_ready);
  end

  // Clear on the committing write, then set on issue so a fresh issue is kept.
  always_comb begin
    busy_nxt = busy;
    if (rf_wen) begin
      busy_nxt[rf_waddr] = 1'b0;
    end
    if (iss_fire) begin
      busy_nxt[iss_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard state.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end
`else
  logic unused_sb_inputs;

  // Without the scoreboard, issue is always accepted and no hazard is reported.
  always_comb begin
    iss_ready        = !rst;
    hazard           = 1'b0;
    unused_sb_inputs = ^{iss_valid, iss_addr, rs1_addr, rs2_addr};
  end
`endif

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Directed self-checking bench for rf_wb_ctrl (both RF_SCOREBOARD_EN builds).
module tb_rf_wb_ctrl;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 64;
  localparam int unsigned NR = 3;
`ifdef RF_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          iss_valid;
  logic [AW-1:0] iss_addr;
  logic          iss_ready;
  logic [AW-1:0] rs1_addr;
  logic [AW-1:0] rs2_addr;
  logic          hazard;

  int n_checks;
  int n_fail;

  rf_wb_ctrl_if #(.NREQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wb_if ();

  rf_wb_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREQ(NR)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb        (wb_if.slave),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .hazard    (hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_if.wb_addr[i*AW +: AW] = a;
    wb_if.wb_data[i*DW +: DW] = d;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    iss_valid = 1'b0; iss_addr = '0; rs1_addr = '0; rs2_addr = '0;
    wb_if.wb_valid = '0; wb_if.wb_addr = '0; wb_if.wb_data = '0;
    step(); step();

    // Reset state; requests and issues are ignored while rst is high
    check("rst_wen",   64'(rf_wen),   64'd0);
    check("rst_waddr", 64'(rf_waddr), 64'd0);
    check("rst_wdata", 64'(rf_wdata), 64'd0);
    set_lane(0, 5'd1, 64'hA1); set_lane(1, 5'd2, 64'hA2); set_lane(2, 5'd3, 64'hA3);
    wb_if.wb_valid = 3'b111; iss_valid = 1'b1; iss_addr = 5'd3; #1;
    check("rst_wb_ready",  64'(wb_if.wb_ready), 64'd0);
    check("rst_iss_ready", 64'(iss_ready),      64'd0);
    step();
    check("rst_no_write", 64'(rf_wen), 64'd0);
    rst = 1'b0; iss_valid = 1'b0; #1;

    // All three request: grants 0,1,2 one per cycle
    check("rr_gnt0", 64'(wb_if.wb_ready), 64'b001);
    step();
    check("rr_w1_wen",   64'(rf_wen),   64'd1);
    check("rr_w1_addr",  64'(rf_waddr), 64'd1);
    check("rr_w1_data",  64'(rf_wdata), 64'hA1);
    check("rr_gnt1", 64'(wb_if.wb_ready), 64'b010);
    step();
    check("rr_w2_addr",  64'(rf_waddr), 64'd2);
    check("rr_w2_data",  64'(rf_wdata), 64'hA2);
    check("rr_gnt2", 64'(wb_if.wb_ready), 64'b100);
    step();
    check("rr_w3_wen",   64'(rf_wen),   64'd1);
    check("rr_w3_addr",  64'(rf_waddr), 64'd3);
    wb_if.wb_valid = '0; #1;
    check("idle_ready", 64'(wb_if.wb_ready), 64'd0);
    step();
    check("idle_wen",   64'(rf_wen),   64'd0);
    check("idle_hold",  64'(rf_waddr), 64'd3);

    // Single requester 1 (ptr=0)
    set_lane(1, 5'd5, 64'hDEAD_BEEF);
    wb_if.wb_valid = 3'b010; #1;
    check("r1_ready", 64'(wb_if.wb_ready), 64'b010);
    step();
    check("r1_wen",  64'(rf_wen),   64'd1);
    check("r1_addr", 64'(rf_waddr), 64'd5);
    check("r1_data", 64'(rf_wdata), 64'hDEAD_BEEF);
    wb_if.wb_valid = '0;
    step();
    check("r1_wen_off", 64'(rf_wen), 64'd0);

    // Pointer wrap: ptr=2, requesters 0 and 1 -> 0 wins
    set_lane(0, 5'd6, 64'h66);
    wb_if.wb_valid = 3'b011; #1;
    check("wrap_ready", 64'(wb_if.wb_ready), 64'b001);
    step();
    check("wrap_addr", 64'(rf_waddr), 64'd6);
    check("wrap_data", 64'(rf_wdata), 64'h66);
    wb_if.wb_valid = '0;

    // Scoreboard: issue x7, source hazard, writeback clears it (ptr=1)
    iss_valid = 1'b1; iss_addr = 5'd7; #1;
    check("iss7_ready",  64'(iss_ready), 64'd1);
    check("iss7_hazard", 64'(hazard),    64'd0);
    step();
    check("iss7_again_ready",  64'(iss_ready), SB ? 64'd0 : 64'd1);
    check("iss7_again_hazard", 64'(hazard),    SB ? 64'd1 : 64'd0);
    iss_valid = 1'b0; rs1_addr = 5'd7; #1;
    check("rs1_7_hazard", 64'(hazard), SB ? 64'd1 : 64'd0);
    set_lane(2, 5'd7, 64'h77);
    wb_if.wb_valid = 3'b100; #1;
    check("wb7_ready", 64'(wb_if.wb_ready), 64'b100);
    step();
    check("wb7_wen",      64'(rf_wen),   64'd1);
    check("wb7_addr",     64'(rf_waddr), 64'd7);
    check("wb7_n1_hazard", 64'(hazard),  SB ? 64'd1 : 64'd0);
    wb_if.wb_valid = '0; iss_valid = 1'b1; iss_addr = 5'd7; #1;
    check("wb7_n1_iss_ready", 64'(iss_ready), SB ? 64'd0 : 64'd1);
    step();
    check("wb7_n2_iss_ready", 64'(iss_ready), 64'd1);
    check("wb7_n2_hazard",    64'(hazard),    64'd0);
    step();
    iss_valid = 1'b0; #1;
    check("reiss7_hazard", 64'(hazard), SB ? 64'd1 : 64'd0);

    // x0: write accepted but not committed; issue to x0 always accepted (ptr=0)
    set_lane(0, 5'd0, 64'h1);
    wb_if.wb_valid = 3'b001; #1;
    check("x0_ready", 64'(wb_if.wb_ready), 64'b001);
    step();
    check("x0_wen", 64'(rf_wen), 64'd0);
    wb_if.wb_valid = '0;
    iss_valid = 1'b1; iss_addr = 5'd0; rs1_addr = 5'd0; rs2_addr = 5'd0; #1;
    check("x0_iss_ready", 64'(iss_ready), 64'd1);
    check("x0_hazard",    64'(hazard),    64'd0);
    step();
    iss_valid = 1'b0; #1;
    check("x0_rs_hazard", 64'(hazard), 64'd0);
    rs2_addr = 5'd7; #1;
    check("rs2_7_hazard", 64'(hazard), SB ? 64'd1 : 64'd0);

    // Reset right after an accept: the write still appears, then all clears (ptr=1)
    set_lane(1, 5'd9, 64'h99);
    wb_if.wb_valid = 3'b010; #1;
    check("pre_rst_ready", 64'(wb_if.wb_ready), 64'b010);
    step();
    wb_if.wb_valid = '0; rst = 1'b1; #1;
    check("rst_cyc_wen",   64'(rf_wen),   64'd1);
    check("rst_cyc_addr",  64'(rf_waddr), 64'd9);
    check("rst_cyc_data",  64'(rf_wdata), 64'h99);
    check("rst_cyc_iss",   64'(iss_ready), 64'd0);
    step();
    check("post_rst_wen",   64'(rf_wen),   64'd0);
    check("post_rst_waddr", 64'(rf_waddr), 64'd0);
    check("post_rst_wdata", 64'(rf_wdata), 64'd0);
    rst = 1'b0; rs1_addr = 5'd7; rs2_addr = 5'd7;
    wb_if.wb_valid = 3'b111; #1;
    check("post_rst_hazard", 64'(hazard),          64'd0);
    check("post_rst_ptr",    64'(wb_if.wb_ready),  64'b001);
    check("post_rst_iss",    64'(iss_ready),       64'd1);
    wb_if.wb_valid = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
